// File: rtl/fat32_write_sequencer.sv
// fat32_write_sequencer
// Issues the SD block-write commands that append one contiguous FAT32 file.
// The command order is: data sectors, then FAT entries (FAT1 and FAT2 copies)
// at every cluster boundary, then the end-of-chain entry, then the directory
// sector. Clusters are allocated contiguously from a firmware-supplied start.
// All outputs come straight from registers.

module fat32_write_sequencer #(
   parameter int unsigned SPC_LOG2         = 3,
   parameter int unsigned theSizeofSectors = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] ReservedSectors,
   input  logic [31:0] theLengthOfFAT,
   input  logic [31:0] theRootDirectory,
   input  logic [31:0] StartCluster,
   input  logic [31:0] DirEntrySector,
   input  logic        sector_req,
   output logic        sector_ack,
   input  logic        close_req,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [1:0]  cmd_type,
   output logic [31:0] cmd_addr,
   output logic [6:0]  fat_index,
   output logic [31:0] fat_value,
   output logic [31:0] file_length,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0]  CMD_DATA     = 2'd0;
   localparam logic [1:0]  CMD_FAT      = 2'd1;
   localparam logic [1:0]  CMD_DIR      = 2'd2;
   localparam logic [31:0] FAT_EOC      = 32'h0FFF_FFFF;
   localparam logic [31:0] SECTOR_BYTES = 32'(theSizeofSectors);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_DATA,
      S_FAT1,
      S_FAT2,
      S_DIR
   } state_t;

   state_t              r_state;
   logic [31:0]         r_cluster;
   logic [31:0]         r_dir_sector;
   logic [SPC_LOG2-1:0] r_sec_cnt;
   logic [31:0]         r_fat_c;
   logic                r_eoc;

   logic                r_sector_ack;
   logic                r_cmd_valid;
   logic [1:0]          r_cmd_type;
   logic [31:0]         r_cmd_addr;
   logic [6:0]          r_fat_index;
   logic [31:0]         r_fat_value;
   logic [31:0]         r_file_length;
   logic                r_busy;
   logic                r_done;

   logic                w_hs;
   logic [31:0]         w_fat1_base;
   logic [31:0]         w_fat2_base;
   logic [SPC_LOG2-1:0] w_sec_next;
   logic                w_cluster_full;
   logic [31:0]         w_close_c;

   // Sector of the data region that holds sector 'sec' of cluster 'clus'.
   function automatic logic [31:0] f_data_addr(input logic [31:0]         root,
                                               input logic [31:0]         clus,
                                               input logic [SPC_LOG2-1:0] sec);
      return root + ((clus - 32'd2) << SPC_LOG2) + 32'(sec);
   endfunction

   // FAT sector that holds the 32-bit entry of cluster 'c' (128 entries per sector).
   function automatic logic [31:0] f_fat_addr(input logic [31:0] base,
                                              input logic [31:0] c);
      return base + (c >> 7);
   endfunction

   assign w_hs           = r_cmd_valid & cmd_ready;
   assign w_fat1_base    = {16'd0, ReservedSectors};
   assign w_fat2_base    = w_fat1_base + theLengthOfFAT;
   assign w_sec_next     = r_sec_cnt + SPC_LOG2'(1);
   assign w_cluster_full = &r_sec_cnt;
   // When the last cluster was filled exactly, its link entry was already
   // written; the end-of-chain marker must overwrite that previous cluster.
   assign w_close_c      = (r_sec_cnt != '0) ? r_cluster : (r_cluster - 32'd1);

   assign sector_ack  = r_sector_ack;
   assign cmd_valid   = r_cmd_valid;
   assign cmd_type    = r_cmd_type;
   assign cmd_addr    = r_cmd_addr;
   assign fat_index   = r_fat_index;
   assign fat_value   = r_fat_value;
   assign file_length = r_file_length;
   assign busy        = r_busy;
   assign done        = r_done;

   // Command sequencer: state, allocation counters and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cluster     <= '0;
         r_dir_sector  <= '0;
         r_sec_cnt     <= '0;
         r_fat_c       <= '0;
         r_eoc         <= 1'b0;
         r_sector_ack  <= 1'b0;
         r_cmd_valid   <= 1'b0;
         r_cmd_type    <= '0;
         r_cmd_addr    <= '0;
         r_fat_index   <= '0;
         r_fat_value   <= '0;
         r_file_length <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_sector_ack <= 1'b0;
         r_done       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cluster     <= StartCluster;
                  r_dir_sector  <= DirEntrySector;
                  r_sec_cnt     <= '0;
                  r_file_length <= '0;
                  r_busy        <= 1'b1;
                  r_state       <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (sector_req) begin
                  r_state     <= S_DATA;
                  r_cmd_valid <= 1'b1;
                  r_cmd_type  <= CMD_DATA;
                  r_cmd_addr  <= f_data_addr(theRootDirectory, r_cluster, r_sec_cnt);
                  r_fat_index <= '0;
                  r_fat_value <= '0;
               end else if (close_req) begin
                  r_cmd_valid <= 1'b1;
                  if (r_file_length == '0) begin
                     // Nothing was allocated: only the directory entry is written.
                     r_state     <= S_DIR;
                     r_cmd_type  <= CMD_DIR;
                     r_cmd_addr  <= r_dir_sector;
                     r_fat_index <= '0;
                     r_fat_value <= '0;
                  end else begin
                     r_state     <= S_FAT1;
                     r_fat_c     <= w_close_c;
                     r_eoc       <= 1'b1;
                     r_cmd_type  <= CMD_FAT;
                     r_cmd_addr  <= f_fat_addr(w_fat1_base, w_close_c);
                     r_fat_index <= w_close_c[6:0];
                     r_fat_value <= FAT_EOC;
                  end
               end
            end
            S_DATA: begin
               if (w_hs) begin
                  r_file_length <= r_file_length + SECTOR_BYTES;
                  r_sector_ack  <= 1'b1;
                  r_sec_cnt     <= w_sec_next;
                  if (w_cluster_full) begin
                     // Cluster full: chain it to the next one straight away.
                     r_state     <= S_FAT1;
                     r_fat_c     <= r_cluster;
                     r_eoc       <= 1'b0;
                     r_cmd_type  <= CMD_FAT;
                     r_cmd_addr  <= f_fat_addr(w_fat1_base, r_cluster);
                     r_fat_index <= r_cluster[6:0];
                     r_fat_value <= r_cluster + 32'd1;
                  end else begin
                     r_cmd_valid <= 1'b0;
                     r_state     <= S_ARMED;
                  end
               end
            end
            S_FAT1: begin
               if (w_hs) begin
                  r_state    <= S_FAT2;
                  r_cmd_addr <= f_fat_addr(w_fat2_base, r_fat_c);
               end
            end
            S_FAT2: begin
               if (w_hs) begin
                  if (r_eoc) begin
                     r_state     <= S_DIR;
                     r_cmd_type  <= CMD_DIR;
                     r_cmd_addr  <= r_dir_sector;
                     r_fat_index <= '0;
                     r_fat_value <= '0;
                  end else begin
                     r_cluster   <= r_cluster + 32'd1;
                     r_cmd_valid <= 1'b0;
                     r_state     <= S_ARMED;
                  end
               end
            end
            S_DIR: begin
               if (w_hs) begin
                  r_cmd_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_cmd_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fat32_write_sequencer.sv
// Testbench for fat32_write_sequencer: directed cases plus randomized files,
// every accepted command compared against a list built from the FAT32
// allocation rules (data sectors, cluster links, end-of-chain, directory).

module tb_fat32_write_sequencer;

   localparam int          SPC_LOG2 = 3;
   localparam int          SPC      = 1 << SPC_LOG2;
   localparam logic [31:0] EOC      = 32'h0FFF_FFFF;

   typedef logic [72:0] cmd_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] ReservedSectors = '0;
   logic [31:0] theLengthOfFAT = '0;
   logic [31:0] theRootDirectory = '0;
   logic [31:0] StartCluster = '0;
   logic [31:0] DirEntrySector = '0;
   logic        sector_req = 1'b0;
   logic        sector_ack;
   logic        close_req = 1'b0;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;
   logic [1:0]  cmd_type;
   logic [31:0] cmd_addr;
   logic [6:0]  fat_index;
   logic [31:0] fat_value;
   logic [31:0] file_length;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_errors = 0;

   cmd_t exp_q[$];
   cmd_t got_q[$];

   always #5 clk = ~clk;

   fat32_write_sequencer #(.SPC_LOG2(SPC_LOG2), .theSizeofSectors(512)) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .ReservedSectors  (ReservedSectors),
      .theLengthOfFAT   (theLengthOfFAT),
      .theRootDirectory (theRootDirectory),
      .StartCluster     (StartCluster),
      .DirEntrySector   (DirEntrySector),
      .sector_req       (sector_req),
      .sector_ack       (sector_ack),
      .close_req        (close_req),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_type         (cmd_type),
      .cmd_addr         (cmd_addr),
      .fat_index        (fat_index),
      .fat_value        (fat_value),
      .file_length      (file_length),
      .busy             (busy),
      .done             (done)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic cmd_t pk(input logic [1:0] t, input logic [31:0] a,
                               input logic [6:0] i, input logic [31:0] v);
      return {t, a, i, v};
   endfunction

   function automatic cmd_t got_at(input int i);
      if (i < got_q.size()) return got_q[i];
      return '0;
   endfunction

   function automatic logic [108:0] all_outs();
      return {cmd_valid, sector_ack, busy, done, cmd_type, cmd_addr,
              fat_index, fat_value, file_length};
   endfunction

   // Both FAT copies of the entry for cluster c.
   task automatic push_fat(input logic [31:0] c, input logic [31:0] v);
      logic [31:0] f1;
      f1 = {16'd0, ReservedSectors} + c / 32'd128;
      exp_q.push_back(pk(2'd1, f1, c[6:0], v));
      exp_q.push_back(pk(2'd1, f1 + theLengthOfFAT, c[6:0], v));
   endtask

   // Reference: sector i of the file lives in cluster sc + i/SPC at offset i%SPC.
   // Each filled cluster links to the next; the last used cluster is end-of-chain.
   task automatic build_expected(input logic [31:0] sc, input logic [31:0] dsec, input int n);
      logic [31:0] cl;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         cl = sc + 32'(i / SPC);
         exp_q.push_back(pk(2'd0, theRootDirectory + (cl - 32'd2) * SPC + 32'(i % SPC), 7'd0, 32'd0));
         if ((i + 1) % SPC == 0) push_fat(cl, cl + 32'd1);
      end
      if (n > 0) begin
         cl = sc + 32'((n - 1) / SPC);
         push_fat(cl, EOC);
      end
      exp_q.push_back(pk(2'd2, dsec, 7'd0, 32'd0));
   endtask

   // mode 0: ready always high; 1: random ready; 2: ready held low 5 cycles on first FAT command.
   // both: close_req held high together with sector_req from the start.
   task automatic run_file(input string nm, input logic [31:0] sc, input logic [31:0] dsec,
                           input int n, input int mode, input bit both);
      int   remaining, cyc, ack_cnt, done_cnt, stab_err, busy_err, gap_err, last_ack, stall_left;
      bit   fin, prev_stall;
      cmd_t prev_f, cur;
      build_expected(sc, dsec, n);
      got_q.delete();
      StartCluster   = sc;
      DirEntrySector = dsec;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      StartCluster   = $urandom;
      DirEntrySector = $urandom;
      remaining  = n;
      sector_req = (n > 0);
      close_req  = both || (n == 0);
      cyc = 0; ack_cnt = 0; done_cnt = 0; stab_err = 0; busy_err = 0; gap_err = 0;
      last_ack = 0; stall_left = 5; fin = 1'b0; prev_stall = 1'b0; prev_f = '0;
      while (!fin && cyc < 2000) begin
         case (mode)
            0: cmd_ready = 1'b1;
            1: cmd_ready = 1'($urandom_range(0, 1));
            default: begin
               if (cmd_valid && cmd_type == 2'd1 && stall_left > 0) begin
                  cmd_ready = 1'b0;
                  stall_left--;
               end else begin
                  cmd_ready = 1'b1;
               end
            end
         endcase
         cur = pk(cmd_type, cmd_addr, fat_index, fat_value);
         if (prev_stall && (!cmd_valid || cur != prev_f)) stab_err++;
         if (!busy) busy_err++;
         if (cmd_valid && cmd_ready) got_q.push_back(cur);
         prev_stall = cmd_valid && !cmd_ready;
         prev_f     = cur;
         @(posedge clk); #1;
         cyc++;
         if (sector_ack) begin
            if (mode == 0 && ack_cnt > 0 && (ack_cnt % SPC) != 0 && (cyc - last_ack) != 2) gap_err++;
            last_ack = cyc;
            ack_cnt++;
            remaining--;
            sector_req = (remaining > 0);
            close_req  = both || (remaining <= 0);
         end
         if (done) begin
            done_cnt++;
            fin = 1'b1;
         end
      end
      chk({nm, "_finished"}, fin, 1'b1);
      sector_req = 1'b0;
      close_req  = 1'b0;
      cmd_ready  = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) done_cnt++;
      end
      chk({nm, "_done_once"}, done_cnt, 1);
      chk({nm, "_acks"}, ack_cnt, n);
      chk({nm, "_file_length"}, file_length, 32'(n * 512));
      chk({nm, "_busy_after"}, busy, 1'b0);
      chk({nm, "_valid_after"}, cmd_valid, 1'b0);
      chk({nm, "_busy_during"}, busy_err, 0);
      chk({nm, "_stable"}, stab_err, 0);
      if (mode == 0) chk({nm, "_throughput"}, gap_err, 0);
      chk({nm, "_ncmd"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("%s_cmd%0d", nm, i), got_at(i), exp_q[i]);
   endtask

   initial begin
      logic [31:0] sc, dsec;
      int          n, mode, vcnt;
      bit          both, hit;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", all_outs(), '0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_outputs", all_outs(), '0);

      ReservedSectors  = 16'd32;
      theLengthOfFAT   = 32'd1000;
      theRootDirectory = 32'd2032;

      run_file("single", 32'd5, 32'd2032, 1, 0, 1'b0);
      chk("single_data_addr", got_at(0), pk(2'd0, 32'd2056, 7'd0, 32'd0));
      chk("single_fat1", got_at(1), pk(2'd1, 32'd32, 7'd5, EOC));
      chk("single_fat2", got_at(2), pk(2'd1, 32'd1032, 7'd5, EOC));
      chk("single_dir", got_at(3), pk(2'd2, 32'd2032, 7'd0, 32'd0));

      run_file("ten", 32'd5, 32'd2032, 10, 0, 1'b0);
      chk("ten_last_data", got_at(7), pk(2'd0, 32'd2063, 7'd0, 32'd0));
      chk("ten_link", got_at(8), pk(2'd1, 32'd32, 7'd5, 32'd6));
      chk("ten_after_link", got_at(10), pk(2'd0, 32'd2064, 7'd0, 32'd0));
      chk("ten_eoc", got_at(12), pk(2'd1, 32'd32, 7'd6, EOC));

      run_file("eight", 32'd5, 32'd2032, 8, 0, 1'b0);
      chk("eight_link", got_at(9), pk(2'd1, 32'd1032, 7'd5, 32'd6));
      chk("eight_eoc_rewrite", got_at(10), pk(2'd1, 32'd32, 7'd5, EOC));

      run_file("c127", 32'd127, 32'd2032, 9, 0, 1'b0);
      chk("c127_link", got_at(8), pk(2'd1, 32'd32, 7'd127, 32'd128));
      chk("c127_eoc1", got_at(11), pk(2'd1, 32'd33, 7'd0, EOC));
      chk("c127_eoc2", got_at(12), pk(2'd1, 32'd1033, 7'd0, EOC));

      run_file("stall", 32'd5, 32'd2032, 10, 2, 1'b1);

      run_file("empty", 32'd5, 32'd2032, 0, 0, 1'b0);
      chk("empty_dir", got_at(0), pk(2'd2, 32'd2032, 7'd0, 32'd0));

      // Randomized files and geometry
      for (int r = 0; r < 14; r++) begin
         ReservedSectors  = 16'($urandom);
         theLengthOfFAT   = $urandom;
         theRootDirectory = $urandom;
         sc   = (r % 3 == 0) ? $urandom : 32'($urandom_range(2, 2000));
         dsec = $urandom;
         n    = $urandom_range(0, 20);
         mode = $urandom_range(0, 2);
         both = 1'($urandom_range(0, 1));
         run_file($sformatf("rnd%0d", r), sc, dsec, n, mode, both);
      end

      // Reset while the FAT2 command is pending
      ReservedSectors  = 16'd32;
      theLengthOfFAT   = 32'd1000;
      theRootDirectory = 32'd2032;
      StartCluster     = 32'd5;
      DirEntrySector   = 32'd2032;
      cmd_ready        = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      sector_req = 1'b1;
      hit = 1'b0;
      for (int k = 0; k < 50 && !hit; k++) begin
         @(posedge clk); #1;
         if (sector_ack) begin
            sector_req = 1'b0;
            close_req  = 1'b1;
         end
         if (cmd_valid && cmd_type == 2'd1 && cmd_addr == 32'd1032) hit = 1'b1;
      end
      chk("rst_reach_fat2", hit, 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_async", all_outs(), '0);
      @(posedge clk); #1;
      chk("rst_edge", all_outs(), '0);
      rst = 1'b0;
      sector_req = 1'b1;
      close_req  = 1'b1;
      vcnt = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (cmd_valid || busy) vcnt++;
      end
      chk("rst_idle", vcnt, 0);
      sector_req = 1'b0;
      close_req  = 1'b0;
      @(posedge clk); #1;

      run_file("after_rst", 32'd5, 32'd2032, 3, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fat32_write_sequencer.md
# fat32_write_sequencer

Sequences every SD block-write command needed to append one contiguous FAT32 file: data sectors, the chained FAT entries in both FAT copies, and the final directory-entry sector. Sits between the data buffer (one request per 512-byte data sector) and the SD-card block-write engine. Takes its region addresses from the root-directory/FAT geometry logic. Clusters are allocated contiguously from a start cluster supplied by firmware.

## Interface
- SPC_LOG2, 3: log2(sectors per cluster); SPC = 2^SPC_LOG2.
- theSizeofSectors, 512: bytes added to file_length per data sector.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a file. Ignored while busy.
- ReservedSectors  in  16  first sector of FAT1.
- theLengthOfFAT  in  32  sectors per FAT; FAT2 base = ReservedSectors + theLengthOfFAT.
- theRootDirectory  in  32  data-region start sector (cluster 2).
- StartCluster  in  32  first cluster of the file, ≥2; latched at start.
- DirEntrySector  in  32  sector holding the file's directory entry; latched at start.
- sector_req  in  1  level; one data sector ready. Held until sector_ack.
- sector_ack  out  1  one-cycle pulse; data command accepted.
- close_req  in  1  level; finalize file. Held until done.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  SD engine accepts command.
- cmd_type  out  2  0 = data, 1 = FAT entry, 2 = directory entry.
- cmd_addr  out  32  target sector.
- fat_index  out  7  entry index within the FAT sector (type 1 only).
- fat_value  out  32  entry value (type 1); 0x0FFFFFFF = end of chain.
- file_length  out  32  bytes written so far.
- busy  out  1  high from start until done.
- done  out  1  one-cycle pulse after the directory command is accepted.

## Operation
- States: IDLE, ARMED, DATA, FAT1, FAT2, DIR.
- IDLE, on start:
  - latch StartCluster into cluster and DirEntrySector;
  - clear sec_cnt (SPC_LOG2 bits) and file_length;
  - busy=1; go to ARMED.
- ARMED, sector_req=1:
  - go to DATA;
  - cmd_type=0, cmd_addr = theRootDirectory + ((cluster−2) << SPC_LOG2) + sec_cnt.
- ARMED, close_req=1, sector_req=0: go to close. sector_req has priority when both are high.
- DATA handshake:
  - file_length += theSizeofSectors; pulse sector_ack; sec_cnt++.
  - If sec_cnt wraps to 0 (cluster full): go to FAT1 with link entry, fat_value = cluster+1.
  - Otherwise return to ARMED.
- FAT1: cmd_type=1, cmd_addr = ReservedSectors + (c >> 7), fat_index = c[6:0]. On handshake go to FAT2.
- FAT2: same fields, cmd_addr plus theLengthOfFAT. On handshake:
  - after a link entry: cluster++, go to ARMED;
  - after an end-of-chain entry: go to DIR.
- Close:
  - file_length=0: straight to DIR.
  - sec_cnt≠0: FAT1/FAT2 with c=cluster, fat_value=0x0FFFFFFF.
  - sec_cnt=0 and file_length>0: FAT1/FAT2 with c=cluster−1, fat_value=0x0FFFFFFF. This overwrites the link entry already written for that cluster.
- DIR: cmd_type=2, cmd_addr=latched DirEntrySector; fat_index=0, fat_value=0. On handshake: pulse done, busy=0, go to IDLE. file_length holds until the next start.
- sector_req and close_req are ignored outside ARMED. Requester holds them.
- All address arithmetic is 32-bit modulo 2^32. No range checking.

## Timing
- Reset: all outputs 0; state IDLE; internal counters 0. Reset mid-command aborts: cmd_valid drops immediately and no further command is issued.
- All outputs are registered.
- Request to command: cmd_valid rises the cycle after sector_req or close_req is sampled in ARMED.
- Handshake = cmd_valid & cmd_ready at a rising edge.
  - cmd_type, cmd_addr, fat_index and fat_value stay stable while cmd_valid & !cmd_ready.
  - cmd_ready while cmd_valid=0 has no effect.
- sector_ack pulses in the cycle after the data handshake. After any handshake that returns to ARMED, cmd_valid is low for exactly one cycle.
- FAT1→FAT2 and FAT2→DIR run back-to-back: cmd_valid stays high and the fields update on the handshake edge.
- done pulses in the cycle after the DIR handshake. start is accepted in that same cycle.
- Throughput with cmd_ready tied high: one data sector every 2 cycles.

## Test plan
Common setup: ReservedSectors=32, theLengthOfFAT=1000, theRootDirectory=2032, SPC_LOG2=3, StartCluster=5, DirEntrySector=2032, cmd_ready=1.
- Single sector: start, 1 sector, close -> data addr 2056; FAT (32, idx 5, 0x0FFFFFFF), then (1032, idx 5, 0x0FFFFFFF); DIR 2032; file_length=512; done pulses once.
- 10 sectors, close -> data addrs 2056–2063, FAT link (32/1032, idx 5, value 6), then addrs 2064–2065, FAT EOC idx 6, DIR; file_length=5120.
- Exact boundary, 8 sectors, close -> link idx 5 value 6, then EOC rewrite idx 5 value 0x0FFFFFFF, DIR.
- StartCluster=127, 9 sectors, close -> link written at 32/1032 idx 127 value 128; EOC at 33/1033 idx 0.
- cmd_ready low 5 cycles during FAT1, sector_req and close_req both high -> fields stable throughout; data takes priority; no lost or duplicate sector_ack.
- Empty file: start, close -> only DIR command; file_length=0. Separately: rst asserted mid-FAT2 -> all outputs 0 next edge; IDLE.
